// File: rtl/serial_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_pkg : shared state encoding, parity codes and helpers for the
//              configurable serial transmitter.
// Revision   : 1.0  initial release
// ----------------------------------------------------------------------------
package serial_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  // 27 MHz / 115200 baud
  localparam int DEFAULT_DIVISOR = 234;

  function automatic logic [3:0] clamp_bits(input logic [3:0] req,
                                            input logic [3:0] max_bits);
    return ((req < 4'd5) || (req > max_bits)) ? max_bits : req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo : single-clock FIFO, show-ahead read, DEPTH a power of two.
// Revision  : 1.0  initial release
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/serial_tx_cfg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_tx_cfg : runtime-configurable UART transmitter with valid/ready input.
//                 Build option SERIAL_TX_FIFO_EN adds a TX FIFO ahead of the framer.
// Revision      : 1.0  initial release
// ----------------------------------------------------------------------------
module serial_tx_cfg
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_BITS   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  dataValid,
  output logic                  ready,
  input  logic [DIV_BITS-1:0]   divisor,
  input  logic [3:0]            dataBits,
  input  logic [1:0]            parityMode,
  input  logic                  stopBits2,
  output logic                  serialOut,
  output logic                  busy,
  output logic                  txDone
);

  localparam logic [DIV_BITS-1:0] CNT_ONE  = {{(DIV_BITS-1){1'b0}}, 1'b1};
  localparam logic [3:0]          MAX_BITS = 4'(DATA_WIDTH);

  tx_state_e             state_q, state_d;
  logic [DIV_BITS-1:0]   cnt_q, cnt_d;
  logic [DIV_BITS-1:0]   div_q, div_d;
  logic [3:0]            idx_q, idx_d;
  logic [3:0]            nbits_q, nbits_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_hi_q, stop_hi_d;
  logic                  serial_q, serial_d;

  logic                  bit_end;
  logic                  stop_last;
  logic                  slot;
  logic                  take;
  logic [DATA_WIDTH-1:0] word;
  logic [DIV_BITS-1:0]   div_eff;
  logic [3:0]            nbits_eff;
  logic [DATA_WIDTH-1:0] mask;
  logic                  par_eff;

  assign bit_end   = (cnt_q == div_q);
  assign stop_last = (state_q == S_STOP) && bit_end && (!stop2_q || stop_hi_q);
  assign slot      = (state_q == S_IDLE) || stop_last;
  assign txDone    = stop_last;
  assign serialOut = serial_q;

`ifdef SERIAL_TX_FIFO_EN
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (dataValid && !fifo_full),
    .push_data (data),
    .pop       (take),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign take  = slot && !fifo_empty;
  assign word  = fifo_head;
  assign ready = !fifo_full;
  assign busy  = (state_q != S_IDLE) || !fifo_empty;
`else
  assign take  = slot && dataValid;
  assign word  = data;
  assign ready = slot;
  assign busy  = (state_q != S_IDLE);
`endif

  // Frame configuration as it will be latched if a word is taken this cycle.
  always_comb begin
    div_eff   = (divisor == '0) ? CNT_ONE : divisor;
    nbits_eff = clamp_bits(dataBits, MAX_BITS);
    mask      = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      mask[i] = (i < int'(nbits_eff));
    end
    par_eff = (^(word & mask)) ^ (parityMode == PAR_ODD);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    idx_d     = idx_q;
    nbits_d   = nbits_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    stop_hi_d = stop_hi_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = CNT_ONE;
          idx_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = CNT_ONE;
          if (idx_q == nbits_q - 4'd1) begin
            state_d   = par_en_q ? S_PARITY : S_STOP;
            stop_hi_d = 1'b0;
          end else begin
            idx_d   = idx_q + 4'd1;
            shreg_d = shreg_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          cnt_d     = CNT_ONE;
          stop_hi_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_hi_q) begin
            stop_hi_d = 1'b1;
            cnt_d     = CNT_ONE;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // take is only ever true in IDLE or the final STOP cycle
    if (take) begin
      state_d   = S_START;
      cnt_d     = CNT_ONE;
      idx_d     = 4'd0;
      shreg_d   = word;
      div_d     = div_eff;
      nbits_d   = nbits_eff;
      par_bit_d = par_eff;
      par_en_d  = (parityMode == PAR_EVEN) || (parityMode == PAR_ODD);
      stop2_d   = stopBits2;
      stop_hi_d = 1'b0;
    end

    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shreg_d[0];
      S_PARITY: serial_d = par_bit_d;
      default:  serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= 4'd0;
      nbits_q   <= MAX_BITS;
      shreg_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      stop_hi_q <= 1'b0;
      serial_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      nbits_q   <= nbits_d;
      shreg_q   <= shreg_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      stop_hi_q <= stop_hi_d;
      serial_q  <= serial_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_cfg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_serial_tx_cfg : directed self-checking bench for serial_tx_cfg.
// Revision         : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_serial_tx_cfg;

  localparam int DW = 8;
  localparam int DB = 16;
  localparam int FD = 4;

  logic          clk        = 1'b0;
  logic          reset      = 1'b0;
  logic [DW-1:0] data       = '0;
  logic          dataValid  = 1'b0;
  logic          ready;
  logic [DB-1:0] divisor    = 16'd4;
  logic [3:0]    dataBits   = 4'd8;
  logic [1:0]    parityMode = 2'b00;
  logic          stopBits2  = 1'b0;
  logic          serialOut;
  logic          busy;
  logic          txDone;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_tx_cfg #(
    .DATA_WIDTH (DW),
    .DIV_BITS   (DB),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .dataValid  (dataValid),
    .ready      (ready),
    .divisor    (divisor),
    .dataBits   (dataBits),
    .parityMode (parityMode),
    .stopBits2  (stopBits2),
    .serialOut  (serialOut),
    .busy       (busy),
    .txDone     (txDone)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int div, input int nb, input int pm, input int s2);
    divisor    = DB'(div);
    dataBits   = 4'(nb);
    parityMode = 2'(pm);
    stopBits2  = 1'(s2);
  endtask

  // Frame already started: these must not affect it.
  task automatic scramble_cfg();
    set_cfg(7, 5, 2, 1);
  endtask

  // Called at a negedge; offers one word and waits for its acceptance edge.
  task automatic send(input string tag, input logic [8:0] w);
    int g = 0;
    data      = w[DW-1:0];
    dataValid = 1'b1;
    while (!ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_eq({tag, " ready"}, 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    dataValid = 1'b0;
`ifndef SERIAL_TX_FIFO_EN
    check_eq({tag, " start latency"}, 32'(serialOut), 32'd0);
    check_eq({tag, " busy latency"}, 32'(busy), 32'd1);
`endif
  endtask

  // Leaves the bench at the negedge of the first start-bit cycle.
  task automatic wait_start(input string tag);
    int g = 0;
    @(negedge clk);
    while (serialOut !== 1'b0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check_eq({tag, " start seen"}, 32'(g < 50), 32'd1);
  endtask

  // Checks one frame cycle by cycle, starting at the current negedge.
  task automatic capture(input string tag, input logic [8:0] w, input int nb,
                         input int has_par, input logic exp_par, input int s2,
                         input int div, input int last, input int drop_valid);
    int   nbit;
    int   len;
    int   b;
    logic lvl;
    nbit = 1 + nb + has_par + (s2 != 0 ? 2 : 1);
    len  = nbit * div;
    for (int c = 0; c < len; c++) begin
      b = c / div;
      if (b == 0)                           lvl = 1'b0;
      else if (b <= nb)                     lvl = w[b-1];
      else if (has_par != 0 && b == nb + 1) lvl = exp_par;
      else                                  lvl = 1'b1;
      check_eq($sformatf("%s line c%0d", tag, c), 32'(serialOut), 32'(lvl));
      check_eq($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
      check_eq($sformatf("%s txDone c%0d", tag, c), 32'(txDone), 32'(c == len - 1));
`ifndef SERIAL_TX_FIFO_EN
      if (c == 0 && len > 1) check_eq({tag, " ready mid-frame"}, 32'(ready), 32'd0);
      if (c == len - 1)      check_eq({tag, " ready last stop"}, 32'(ready), 32'd1);
`endif
      if (c == len - 1 && drop_valid != 0) begin
        @(posedge clk);
        #1;
        dataValid = 1'b0;
      end
      @(negedge clk);
    end
    if (last != 0) begin
      check_eq({tag, " idle busy"}, 32'(busy), 32'd0);
      check_eq({tag, " idle line"}, 32'(serialOut), 32'd1);
      check_eq({tag, " idle txDone"}, 32'(txDone), 32'd0);
    end
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check_eq("reset line", 32'(serialOut), 32'd1);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset txDone", 32'(txDone), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("reset ready", 32'(ready), 32'd1);
    @(negedge clk);

    // 8N1, divisor 4: 0xA5
    set_cfg(4, 8, 0, 0);
    send("8n1", 9'h0A5);
    wait_start("8n1");
    scramble_cfg();
    capture("8n1", 9'h0A5, 8, 0, 1'b0, 0, 4, 1, 0);

    // 0xA5 has four ones: even parity 0, odd parity 1
    set_cfg(4, 8, 1, 0);
    send("even", 9'h0A5);
    wait_start("even");
    scramble_cfg();
    capture("even", 9'h0A5, 8, 1, 1'b0, 0, 4, 1, 0);

    set_cfg(4, 8, 2, 0);
    send("odd", 9'h0A5);
    wait_start("odd");
    scramble_cfg();
    capture("odd", 9'h0A5, 8, 1, 1'b1, 0, 4, 1, 0);

    // 7 bits of 0xA5 = 1,0,1,0,0,1,0 -> three ones, even parity 1; two stops
    set_cfg(4, 7, 1, 1);
    send("7e2", 9'h0A5);
    wait_start("7e2");
    scramble_cfg();
    capture("7e2", 9'h0A5, 7, 1, 1'b1, 1, 4, 1, 0);

    // parity code 11 means none; six bits of 0x2B
    set_cfg(3, 6, 3, 0);
    send("6n1", 9'h02B);
    wait_start("6n1");
    scramble_cfg();
    capture("6n1", 9'h02B, 6, 0, 1'b0, 0, 3, 1, 0);

    // divisor 0 -> 1, dataBits 3 -> 8; 0x3C has four ones -> odd parity 1
    set_cfg(0, 3, 2, 0);
    send("clamp", 9'h03C);
    wait_start("clamp");
    capture("clamp", 9'h03C, 8, 1, 1'b1, 0, 1, 1, 0);

    // back-to-back, divisor 2
    set_cfg(2, 8, 0, 0);
    data      = 8'h55;
    dataValid = 1'b1;
    @(posedge clk);
    #1;
    data = 8'h0F;
`ifdef SERIAL_TX_FIFO_EN
    @(posedge clk);
    #1;
    dataValid = 1'b0;
`endif
    wait_start("b2b");
    capture("b2b w0", 9'h055, 8, 0, 1'b0, 0, 2, 0, 1);
    capture("b2b w1", 9'h00F, 8, 0, 1'b0, 0, 2, 1, 0);

    // asynchronous reset mid-DATA
    set_cfg(4, 8, 0, 0);
    send("rst", 9'h000);
    wait_start("rst");
    repeat (6) @(negedge clk);
    check_eq("rst pre line", 32'(serialOut), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("rst async line", 32'(serialOut), 32'd1);
    check_eq("rst async busy", 32'(busy), 32'd0);
    check_eq("rst async txDone", 32'(txDone), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst ready", 32'(ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check_eq("rst idle line", 32'(serialOut), 32'd1);
      check_eq("rst idle busy", 32'(busy), 32'd0);
    end
    send("post-rst", 9'h096);
    wait_start("post-rst");
    capture("post-rst", 9'h096, 8, 0, 1'b0, 0, 4, 1, 0);

`ifdef SERIAL_TX_FIFO_EN
    begin
      logic [7:0] words [5];
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
      words[3] = 8'h44; words[4] = 8'h55;
      set_cfg(2, 8, 0, 0);
      fork
        begin
          for (int i = 0; i < 5; i++) begin
            data      = words[i];
            dataValid = 1'b1;
            check_eq($sformatf("fifo ready w%0d", i), 32'(ready), 32'd1);
            @(posedge clk);
            #1;
          end
          data = 8'hEE;
          @(negedge clk);
          check_eq("fifo full ready", 32'(ready), 32'd0);
          repeat (3) begin
            @(posedge clk);
            #1;
          end
          dataValid = 1'b0;
        end
        begin
          wait_start("fifo");
          for (int i = 0; i < 5; i++) begin
            capture($sformatf("fifo w%0d", i), {1'b0, words[i]}, 8, 0, 1'b0, 0, 2,
                    (i == 4) ? 1 : 0, 0);
          end
        end
      join
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
